// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with a direct-mapped BTB feeding next-PC selection.
// Latency: the selected next PC appears on pc_if one clock edge later; redirects cost no extra bubble.
// Backpressure: stall holds pc_if; redirect_valid overrides stall and the boot state.
module fetch_pc_unit #(
  parameter int XLEN = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            bp_prediction,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_is_jump,
  input  logic            btb_flush,
  output logic [XLEN-1:0] pc_if,
  output logic            pc_valid,
  output logic            predict_enable,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(3));

  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t state, state_next;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
  logic                   btb_jump   [BTB_ENTRIES];

  logic [IDX_W-1:0] look_idx, upd_idx;
  logic [TAG_W-1:0] look_tag, upd_tag;
  logic             btb_hit;
  logic             btb_write;
  logic [XLEN-1:0]  next_pc;

  // Index and tag are taken from the word address; the byte offset never matters.
  assign look_idx = IDX_W'(pc_if >> 2);
  assign look_tag = TAG_W'(pc_if >> (IDX_W + 2));
  assign upd_idx  = IDX_W'(upd_pc >> 2);
  assign upd_tag  = TAG_W'(upd_pc >> (IDX_W + 2));

  // Only taken resolutions allocate; direction for not-taken is the predictor's job.
  assign btb_write = upd_valid & upd_taken;

  // State register: boot lasts exactly one cycle after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_BOOT;
    else       state <= state_next;
  end

  // Next-state logic: boot always advances, run is terminal.
  always_comb begin
    state_next = state;
    if (state == S_BOOT) state_next = S_RUN;
  end

  // Output logic: fetches are only real once running.
  always_comb begin
    pc_valid = (state == S_RUN);
  end

  assign predict_enable = pc_valid & ~stall;

  // Combinational BTB lookup on the current fetch PC.
  always_comb begin
    btb_hit     = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
    pred_taken  = pc_valid & btb_hit & (btb_jump[look_idx] | bp_prediction);
    pred_target = btb_hit ? btb_target[look_idx] : '0;
  end

  // Next-PC priority: redirect, then boot/stall hold, then prediction, then sequential.
  always_comb begin
    next_pc = pc_if + PC_STEP;
    if (redirect_valid)         next_pc = redirect_pc & WORD_MASK;
    else if (state == S_BOOT)   next_pc = pc_if;
    else if (stall)             next_pc = pc_if;
    else if (pred_taken)        next_pc = pred_target;
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_if <= RESET_PC;
    else       pc_if <= next_pc;
  end

  // Valid bits: flush wins over a same-cycle allocation so the entry ends invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          btb_valid <= '0;
    else if (btb_flush) btb_valid <= '0;
    else if (btb_write) btb_valid[upd_idx] <= 1'b1;
  end

  // Entry payload; contents are meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (btb_write && !btb_flush) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= upd_target & WORD_MASK;
      btb_jump[upd_idx]   <= upd_is_jump;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bp_prediction;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_is_jump;
  logic        btb_flush;
  logic [31:0] pc_if;
  logic        pc_valid;
  logic        predict_enable;
  logic        pred_taken;
  logic [31:0] pred_target;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit #(
    .XLEN(32), .BTB_ENTRIES(16), .IDX_W(4), .RESET_PC(32'h100)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bp_prediction(bp_prediction),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_is_jump(upd_is_jump), .btb_flush(btb_flush),
    .pc_if(pc_if), .pc_valid(pc_valid), .predict_enable(predict_enable),
    .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are changed and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic jmp);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = 1'b1; upd_is_jump = jmp;
    step();
    upd_valid = 1'b0; upd_taken = 1'b0; upd_is_jump = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bp_prediction = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; upd_is_jump = 1'b0; btb_flush = 1'b0;
    #2;
    checks++; if (pc_if !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_if, 32'h100); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pc_valid); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_pred_target: got %h expected 0", pred_target); end
    #10;
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    checks++; if (pc_valid !== 1'b0 || pc_if !== 32'h100) begin errors++; $display("FAIL boot: got pc=%h valid=%b expected pc=100 valid=0", pc_if, pc_valid); end
    step();
    checks++; if (pc_valid !== 1'b1 || pc_if !== 32'h100) begin errors++; $display("FAIL first_fetch: got pc=%h valid=%b expected pc=100 valid=1", pc_if, pc_valid); end
    checks++; if (predict_enable !== 1'b1) begin errors++; $display("FAIL predict_enable: got %b expected 1", predict_enable); end
    step();
    checks++; if (pc_if !== 32'h104) begin errors++; $display("FAIL seq_104: got %h expected 104", pc_if); end
    step();
    checks++; if (pc_if !== 32'h108) begin errors++; $display("FAIL seq_108: got %h expected 108", pc_if); end
  endtask

  task automatic test_train();
    // Train while sitting on 0x108: the lookup this cycle must still see the empty entry.
    bp_prediction = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h108; upd_target = 32'h200; upd_taken = 1'b1; upd_is_jump = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_old_entry: got %b expected 0", pred_taken); end
    step();
    upd_valid = 1'b0; upd_taken = 1'b0;
    checks++; if (pc_if !== 32'h10C) begin errors++; $display("FAIL train_seq: got %h expected 10c", pc_if); end
    redirect_to(32'h108);
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin errors++; $display("FAIL hit_taken: got taken=%b tgt=%h expected 1 200", pred_taken, pred_target); end
    step();
    checks++; if (pc_if !== 32'h200) begin errors++; $display("FAIL hit_next: got %h expected 200", pc_if); end
    // Same entry, predictor says not taken.
    redirect_to(32'h108);
    bp_prediction = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL hit_not_taken: got %b expected 0", pred_taken); end
    step();
    checks++; if (pc_if !== 32'h10C) begin errors++; $display("FAIL not_taken_next: got %h expected 10c", pc_if); end
  endtask

  task automatic test_jump();
    // JAL at 0x10C with a misaligned target; stored target drops bits [1:0].
    train(32'h10C, 32'h303, 1'b1);
    redirect_to(32'h10C);
    bp_prediction = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin errors++; $display("FAIL jal_hit: got taken=%b tgt=%h expected 1 300", pred_taken, pred_target); end
    step();
    checks++; if (pc_if !== 32'h300) begin errors++; $display("FAIL jal_next: got %h expected 300", pc_if); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (predict_enable !== 1'b0) begin errors++; $display("FAIL stall_pe: got %b expected 0", predict_enable); end
    step();
    checks++; if (pc_if !== 32'h300) begin errors++; $display("FAIL stall_hold: got %h expected 300", pc_if); end
    redirect_to(32'h403);
    checks++; if (pc_if !== 32'h400 || pc_valid !== 1'b1) begin errors++; $display("FAIL stall_redirect: got pc=%h valid=%b expected 400 1", pc_if, pc_valid); end
    stall = 1'b0;
  endtask

  task automatic test_alias();
    train(32'h008, 32'h500, 1'b0);
    redirect_to(32'h048);
    bp_prediction = 1'b1;
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin errors++; $display("FAIL alias_miss: got taken=%b tgt=%h expected 0 0", pred_taken, pred_target); end
    step();
    checks++; if (pc_if !== 32'h04C) begin errors++; $display("FAIL alias_next: got %h expected 4c", pc_if); end
    redirect_to(32'h008);
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h500) begin errors++; $display("FAIL alias_owner_hit: got taken=%b tgt=%h expected 1 500", pred_taken, pred_target); end
  endtask

  task automatic test_wrap();
    bp_prediction = 1'b0;
    redirect_to(32'hFFFF_FFFC);
    checks++; if (pc_if !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start: got %h expected fffffffc", pc_if); end
    step();
    checks++; if (pc_if !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", pc_if); end
  endtask

  task automatic test_flush();
    btb_flush = 1'b1;
    train(32'h008, 32'h600, 1'b1);
    btb_flush = 1'b0;
    bp_prediction = 1'b1;
    redirect_to(32'h008);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL flush_beats_upd: got %b expected 0", pred_taken); end
    redirect_to(32'h108);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL flush_old_entry: got %b expected 0", pred_taken); end
    step();
    checks++; if (pc_if !== 32'h10C) begin errors++; $display("FAIL flush_next: got %h expected 10c", pc_if); end
  endtask

  task automatic test_async_reset();
    redirect_to(32'h700);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (pc_if !== 32'h100 || pc_valid !== 1'b0) begin errors++; $display("FAIL async_reset: got pc=%h valid=%b expected 100 0", pc_if, pc_valid); end
    #3;
    reset = 1'b0;
    step();
    checks++; if (pc_if !== 32'h100 || pc_valid !== 1'b1) begin errors++; $display("FAIL post_reset: got pc=%h valid=%b expected 100 1", pc_if, pc_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_train();
    test_jump();
    test_stall();
    test_alias();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
